// File: rtl/inertial_intf.sv
// Inertial sensor front end: configures the IMU over the SPI transaction port after reset,
// then reads pitch rate and Z acceleration on every data-ready interrupt.
module inertial_intf #(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  typedef enum logic [1:0] {INIT_WAIT, CFG, IDLE, READ} state_e;

  localparam logic [INIT_WAIT_BITS-1:0] WAIT_ONE = INIT_WAIT_BITS'(1);

  state_e                    state_q;
  logic [INIT_WAIT_BITS-1:0] wait_cnt_q;
  logic [1:0]                idx_q;
  logic [1:0]                idx_d;
  logic                      int_ff1_q;
  logic                      int_ff2_q;
  logic                      wrt_q;
  logic                      vld_q;
  logic [15:0]               cmd_q;
  logic [15:0]               ptch_rt_q;
  logic [15:0]               az_q;
  logic [7:0]                pitch_lo_q;
  logic [7:0]                pitch_hi_q;
  logic [7:0]                az_lo_q;
  logic                      done_ok;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_cmd = 16'h0D02;
      2'd1:    cfg_cmd = 16'h1053;
      2'd2:    cfg_cmd = 16'h1150;
      default: cfg_cmd = 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] read_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    read_cmd = 16'hA200;
      2'd1:    read_cmd = 16'hA300;
      2'd2:    read_cmd = 16'hAC00;
      default: read_cmd = 16'hAD00;
    endcase
  endfunction

  assign idx_d = idx_q + 2'd1;

  // A done in the same cycle as our own wrt cannot belong to that transaction.
  assign done_ok = done & ~wrt_q;

  // NOTE: wrt and vld default low every clock, so a single assignment makes a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_WAIT;
      wait_cnt_q <= '0;
      idx_q      <= 2'd0;
      int_ff1_q  <= 1'b0;
      int_ff2_q  <= 1'b0;
      wrt_q      <= 1'b0;
      vld_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      ptch_rt_q  <= 16'h0000;
      az_q       <= 16'h0000;
      pitch_lo_q <= 8'h00;
      pitch_hi_q <= 8'h00;
      az_lo_q    <= 8'h00;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      wrt_q     <= 1'b0;
      vld_q     <= 1'b0;

      case (state_q)
        INIT_WAIT: begin
          if (&wait_cnt_q) begin
            state_q <= CFG;
            idx_q   <= 2'd0;
            wrt_q   <= 1'b1;
            cmd_q   <= cfg_cmd(2'd0);
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_ONE;
          end
        end

        CFG: begin
          if (done_ok) begin
            if (idx_q == 2'd3) begin
              state_q <= IDLE;
            end else begin
              idx_q <= idx_d;
              wrt_q <= 1'b1;
              cmd_q <= cfg_cmd(idx_d);
            end
          end
        end

        IDLE: begin
          if (int_ff2_q) begin
            state_q <= READ;
            idx_q   <= 2'd0;
            wrt_q   <= 1'b1;
            cmd_q   <= read_cmd(2'd0);
          end
        end

        READ: begin
          if (done_ok) begin
            // Pitch-high and AZ-low are staged so both outputs switch on the last byte.
            case (idx_q)
              2'd0:    pitch_lo_q <= rd_data[7:0];
              2'd1:    pitch_hi_q <= rd_data[7:0];
              2'd2:    az_lo_q    <= rd_data[7:0];
              default: begin
                ptch_rt_q <= {pitch_hi_q, pitch_lo_q};
                az_q      <= {rd_data[7:0], az_lo_q};
                vld_q     <= 1'b1;
                state_q   <= IDLE;
              end
            endcase
            if (idx_q != 2'd3) begin
              idx_q <= idx_d;
              wrt_q <= 1'b1;
              cmd_q <= read_cmd(idx_d);
            end
          end
        end

        default: state_q <= INIT_WAIT;
      endcase
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign ptch_rt = ptch_rt_q;
  assign AZ      = az_q;
  assign vld     = vld_q;

endmodule

// File: tb/tb_inertial_intf.sv
// Self-checking bench for inertial_intf: SPI responder model, output coherence monitor and
// scenario tasks covering config, reads, back-to-back bursts, stray done and reset abort.
module tb_inertial_intf;

  localparam int WB        = 4;
  localparam int SPI_DELAY = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;

  int checks = 0;
  int errors = 0;

  // Responder / monitor state
  int          cyc         = 0;
  int          pend        = 0;
  int          done_count  = 0;
  int          vld_count   = 0;
  int          last_ad_cyc = -10;
  bit          fixed_en    = 1'b0;
  bit          inject_done = 1'b0;
  logic [15:0] cur_cmd     = 16'h0000;
  logic [7:0]  fixed_tbl [4];
  logic [7:0]  served    [4];
  logic [15:0] cmd_log [$];
  logic        prev_rst    = 1'b1;
  logic        prev_wrt    = 1'b0;
  logic [15:0] prev_p      = 16'h0000;
  logic [15:0] prev_a      = 16'h0000;

  logic [15:0] cfg_list [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_list  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  inertial_intf #(.INIT_WAIT_BITS(WB)) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .ptch_rt (ptch_rt),
    .AZ      (AZ),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  function automatic int rd_slot(input logic [7:0] addr);
    case (addr)
      8'hA2:   return 0;
      8'hA3:   return 1;
      8'hAC:   return 2;
      8'hAD:   return 3;
      default: return -1;
    endcase
  endfunction

  // SPI engine model plus output monitor, evaluated just after every rising edge.
  initial begin
    logic [7:0] byte_v;
    int         slot;
    done    = 1'b0;
    rd_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst && !prev_rst) begin
        checks++;
        if (wrt && prev_wrt) begin
          errors++;
          $display("FAIL wrt_width: wrt high two cycles, cmd %h", cmd);
        end
        if (vld) begin
          vld_count++;
          checks++;
          if (ptch_rt !== {served[1], served[0]} || AZ !== {served[3], served[2]}) begin
            errors++;
            $display("FAIL sample_value: ptch_rt %h AZ %h, expected %h %h",
                     ptch_rt, AZ, {served[1], served[0]}, {served[3], served[2]});
          end
          checks++;
          if (cyc !== last_ad_cyc + 1) begin
            errors++;
            $display("FAIL vld_timing: vld at cycle %0d, expected %0d", cyc, last_ad_cyc + 1);
          end
        end else begin
          checks++;
          if (ptch_rt !== prev_p || AZ !== prev_a) begin
            errors++;
            $display("FAIL coherence: outputs moved without vld, ptch_rt %h->%h AZ %h->%h",
                     prev_p, ptch_rt, prev_a, AZ);
          end
        end
      end
      prev_rst = rst;
      prev_wrt = wrt;
      prev_p   = ptch_rt;
      prev_a   = AZ;

      done = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          slot   = rd_slot(cur_cmd[15:8]);
          byte_v = (fixed_en && slot >= 0) ? fixed_tbl[slot] : 8'($urandom);
          checks++;
          if (cmd !== cur_cmd) begin
            errors++;
            $display("FAIL cmd_hold: cmd %h at done, expected %h", cmd, cur_cmd);
          end
          done    = 1'b1;
          rd_data = {8'($urandom), byte_v};
          if (slot >= 0) served[slot] = byte_v;
          if (slot == 3) last_ad_cyc = cyc;
          done_count++;
        end
      end else if (inject_done) begin
        done        = 1'b1;
        rd_data     = 16'($urandom);
        inject_done = 1'b0;
      end

      if (wrt && !rst) begin
        cmd_log.push_back(cmd);
        cur_cmd = cmd;
        pend    = SPI_DELAY;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_dones(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_vld(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (vld_count >= target && vld === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    INT = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wrt, vld, cmd, ptch_rt, AZ} !== '0) begin
      errors++;
      $display("FAIL reset_state: wrt %b vld %b cmd %h ptch_rt %h AZ %h, expected all 0",
               wrt, vld, cmd, ptch_rt, AZ);
    end
  endtask

  task automatic test_config;
    int n;
    int start;
    bit ok;
    cmd_log.delete();
    start = done_count;
    rst   = 1'b0;
    n     = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (wrt === 1'b1) break;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL init_wait: first wrt after %0d clocks, expected 16", n);
    end
    wait_dones(start + 4, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || cmd_log.size() !== 4) begin
      errors++;
      $display("FAIL cfg_count: %0d commands (ok=%0b), expected 4", cmd_log.size(), ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cmd_log[i] !== cfg_list[i]) begin
          errors++;
          $display("FAIL cfg_cmd%0d: got %h expected %h", i, cmd_log[i], cfg_list[i]);
        end
      end
    end
    checks++;
    if (vld_count !== 0) begin
      errors++;
      $display("FAIL cfg_vld: %0d vld pulses during config, expected 0", vld_count);
    end
  endtask

  task automatic test_int_latency;
    int n;
    int base;
    int log_base;
    bit ok;
    fixed_en  = 1'b1;
    fixed_tbl = '{8'h50, 8'h10, 8'h00, 8'h08};
    base      = vld_count;
    log_base  = cmd_log.size();
    @(negedge clk);
    INT = 1'b1;
    n   = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (wrt === 1'b1) break;
    end
    INT = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL int_latency: first read wrt %0d clocks after INT, expected 3", n);
    end
    wait_vld(base + 1, ok);
    checks++;
    if (!ok || ptch_rt !== 16'h1050 || AZ !== 16'h0800) begin
      errors++;
      $display("FAIL read_fixed: ok=%0b ptch_rt %h AZ %h, expected 1050 0800", ok, ptch_rt, AZ);
    end
    @(negedge clk);
    checks++;
    if (vld !== 1'b0) begin
      errors++;
      $display("FAIL vld_width: vld %b on second cycle, expected 0", vld);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_log.size() <= log_base + i || cmd_log[log_base + i] !== rd_list[i]) begin
        errors++;
        $display("FAIL read_cmd%0d: log size %0d, expected cmd %h", i, cmd_log.size(), rd_list[i]);
      end
    end
  endtask

  task automatic test_negative;
    int base_d;
    int base_v;
    bit ok;
    fixed_tbl = '{8'hB0, 8'hFF, 8'h00, 8'hF8};
    base_d    = done_count;
    base_v    = vld_count;
    @(negedge clk);
    INT = 1'b1;
    @(negedge clk);
    INT = 1'b0;
    wait_dones(base_d + 3, ok);
    @(negedge clk);
    checks++;
    if (!ok || ptch_rt !== 16'h1050 || AZ !== 16'h0800) begin
      errors++;
      $display("FAIL staged_hold: ok=%0b ptch_rt %h AZ %h after 3 dones, expected 1050 0800",
               ok, ptch_rt, AZ);
    end
    wait_vld(base_v + 1, ok);
    checks++;
    if (!ok || $signed(ptch_rt) !== -16'sd80 || $signed(AZ) !== -16'sd2048) begin
      errors++;
      $display("FAIL signed_sample: ok=%0b ptch_rt %0d AZ %0d, expected -80 -2048",
               ok, $signed(ptch_rt), $signed(AZ));
    end
    fixed_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int          log_base;
    int          base_v;
    int          log_sz;
    logic [15:0] p_sav;
    logic [15:0] a_sav;
    bit          ok;
    log_base = cmd_log.size();
    @(negedge clk);
    INT = 1'b1;
    for (int b = 0; b < 3; b++) begin
      base_v = vld_count;
      wait_vld(base_v + 1, ok);
      @(negedge clk);
      checks++;
      if (!ok || wrt !== 1'b1 || cmd !== 16'hA200) begin
        errors++;
        $display("FAIL back_to_back%0d: ok=%0b wrt %b cmd %h, expected 1 A200", b, ok, wrt, cmd);
      end
    end
    INT = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (cmd_log.size() - log_base < 12 || (cmd_log.size() - log_base) % 4 != 0) begin
      errors++;
      $display("FAIL burst_count: %0d read commands, expected a multiple of 4 >= 12",
               cmd_log.size() - log_base);
    end
    for (int i = log_base; i < cmd_log.size(); i++) begin
      checks++;
      if (cmd_log[i] !== rd_list[(i - log_base) % 4]) begin
        errors++;
        $display("FAIL burst_order: entry %0d got %h expected %h",
                 i, cmd_log[i], rd_list[(i - log_base) % 4]);
      end
    end
    base_v = vld_count;
    log_sz = cmd_log.size();
    p_sav  = ptch_rt;
    a_sav  = AZ;
    for (int k = 0; k < 3; k++) begin
      inject_done = 1'b1;
      repeat (5) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (vld_count !== base_v || cmd_log.size() !== log_sz || ptch_rt !== p_sav || AZ !== a_sav) begin
      errors++;
      $display("FAIL stray_done: vld %0d->%0d cmds %0d->%0d ptch_rt %h AZ %h, expected unchanged",
               base_v, vld_count, log_sz, cmd_log.size(), ptch_rt, AZ);
    end
  endtask

  task automatic test_reset_mid_read;
    int base_d;
    int log_base;
    int start;
    int n;
    bit ok;
    base_d   = done_count;
    log_base = cmd_log.size();
    @(negedge clk);
    INT = 1'b1;
    @(negedge clk);
    INT = 1'b0;
    wait_dones(base_d + 1, ok);
    for (int i = 0; i < 50 && cmd_log.size() < log_base + 2; i++) @(negedge clk);
    checks++;
    if (!ok || cmd_log.size() < log_base + 2) begin
      errors++;
      $display("FAIL abort_setup: ok=%0b %0d read cmds, expected 2", ok, cmd_log.size() - log_base);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wrt, vld, cmd, ptch_rt, AZ} !== '0) begin
      errors++;
      $display("FAIL abort_clear: wrt %b vld %b cmd %h ptch_rt %h AZ %h, expected all 0",
               wrt, vld, cmd, ptch_rt, AZ);
    end
    cmd_log.delete();
    start = done_count;
    rst   = 1'b0;
    n     = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) inject_done = 1'b1;
      if (wrt === 1'b1) break;
      INT = 1'($urandom_range(0, 1));
    end
    checks++;
    if (n !== 16 || cmd !== 16'h0D02) begin
      errors++;
      $display("FAIL reinit: first wrt after %0d clocks cmd %h, expected 16 0D02", n, cmd);
    end
    while (done_count < start + 2 && n < 400) begin
      @(negedge clk);
      n++;
      INT = 1'($urandom_range(0, 1));
    end
    INT = 1'b0;
    wait_dones(start + 4, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || cmd_log.size() !== 4) begin
      errors++;
      $display("FAIL recfg_count: ok=%0b %0d commands, expected 4", ok, cmd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cmd_log[i] !== cfg_list[i]) begin
          errors++;
          $display("FAIL recfg_cmd%0d: got %h expected %h", i, cmd_log[i], cfg_list[i]);
        end
      end
    end
  endtask

  task automatic test_idle_quiet;
    int base_v;
    base_v = vld_count;
    repeat (200) @(negedge clk);
    checks++;
    if (vld_count !== base_v || cmd_log.size() !== 4 || ptch_rt !== 16'h0000 || AZ !== 16'h0000) begin
      errors++;
      $display("FAIL idle_quiet: vld %0d->%0d cmds %0d ptch_rt %h AZ %h, expected no activity",
               base_v, vld_count, cmd_log.size(), ptch_rt, AZ);
    end
  endtask

  initial begin
    rst         = 1'b1;
    INT         = 1'b0;
    fixed_tbl   = '{8'h00, 8'h00, 8'h00, 8'h00};
    served      = '{8'h00, 8'h00, 8'h00, 8'h00};
    test_reset;
    test_config;
    test_int_latency;
    test_negative;
    test_back_to_back;
    test_reset_mid_read;
    test_idle_quiet;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inertial_intf.md
Name: inertial_intf

Overview:
Front end of the balance path. It configures the 6-axis inertial sensor over a 16-bit SPI transaction port after reset. It then reads pitch rate and Z-axis acceleration on every sensor data-ready interrupt and presents `ptch_rt`, `AZ` and a one-clock `vld` to the inertial integrator directly downstream. The SPI bit-level engine is a separate block; this block only sequences commands and assembles the returned bytes.

Parameters:
INIT_WAIT_BITS, 16, width of the power-up wait counter; configuration starts when the counter reaches all-ones (2^16-1 clocks by default).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
INT  input  1  sensor data-ready interrupt, asynchronous, active-high level
done  input  1  one-clock pulse from SPI engine: transaction complete
rd_data  input  16  SPI read word; bits [7:0] valid in the cycle done=1
wrt  output  1  one-clock request to SPI engine to start a transaction
cmd  output  16  command word for SPI engine; held stable from the wrt cycle until done
ptch_rt  output  16  signed pitch rate, {high byte, low byte}
AZ  output  16  signed Z acceleration, {high byte, low byte}
vld  output  1  one-clock pulse: ptch_rt and AZ hold a new coherent sample

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high. Every flop clears on the first `clk` edge with rst=1.
- Reset values: wrt=0, cmd=0, ptch_rt=0, AZ=0, vld=0, wait counter=0, state=INIT_WAIT, INT sync flops=0.
- INT passes through a 2-flop synchronizer. Only the synchronized level (INT_ff2) is used.
- States and transitions:
  - INIT_WAIT: counter increments every clock. When it is all-ones, go to CFG with cfg index 0.
  - CFG: issue four writes in order: 16'h0D02 (INT on data-ready), 16'h1053 (accel 208 Hz), 16'h1150 (gyro 208 Hz), 16'h1460 (rounding on).
  - Each transaction: wrt=1 for exactly the first cycle, cmd presented in that same cycle, then hold and wait for done. The next transaction's wrt is asserted in the cycle after done (one gap cycle minimum).
  - After done of 16'h1460, go to IDLE.
  - IDLE: when INT_ff2=1, go to READ.
  - READ: issue four reads in order: 16'hA2xx (pitch low), 16'hA3xx (pitch high), 16'hACxx (AZ low), 16'hADxx (AZ high). Low byte of cmd is 8'h00.
- Byte capture: on each read's done cycle, rd_data[7:0] is latched into a byte holding register.
- Output update: ptch_rt and AZ update together on the final done (AZ-high done).
  - ptch_rt <= {pitch_hi, pitch_lo}; AZ <= {rd_data[7:0], AZ_lo}.
  - Outputs never show a half-updated sample. Pitch-high and AZ-low bytes are staged internally until the final done.
- vld=1 for exactly the single cycle after the final done, when the new values are first visible on ptch_rt/AZ. Return to IDLE in that same cycle.
- Back-to-back samples: if INT_ff2 is still or again high in IDLE, the next READ starts on the next clock. INT activity during CFG or READ is ignored. No interrupt is queued beyond the current level.
- Stray done (in INIT_WAIT, IDLE, or extra pulses): ignored. No state change, no capture.
- rd_data[15:8] is ignored everywhere.
- Reset asserted mid-transaction: everything clears and the full INIT_WAIT is repeated. A later done from the aborted transaction is ignored.
- Wait counter saturates at all-ones and is not reused after INIT_WAIT.
- No combinational path from any input to any output. wrt, cmd and vld are registered.

Test Plan:
1. INIT_WAIT_BITS=4 with a bench SPI model answering done 10 clocks after wrt -> first wrt occurs 16 clocks after reset release. cmd sequence is 0D02, 1053, 1150, 1460, each wrt exactly 1 cycle. No vld during config.
2. After config, pulse INT high. Model returns low bytes 0x50, 0x10, 0x00, 0x08 for reads A2, A3, AC, AD -> ptch_rt=16'h1050, AZ=16'h0800. vld is one cycle, in the cycle after the AD done. Synchronized INT-to-first-read-wrt latency is 3 clocks from the INT rising edge (2 sync flops + IDLE decision).
3. Model returns pitch 0xFFB0 and AZ 0xF800 -> ptch_rt=-80 signed, AZ=-2048. Check ptch_rt/AZ stay unchanged through the first three dones and flip simultaneously.
4. Hold INT high continuously -> read bursts repeat back to back, one vld per 4-read burst. Inject extra done pulses while in IDLE -> no capture, no vld.
5. Assert rst during the second read (after one done) -> all outputs 0 the next clock, wait counter restarts, config sequence re-issues from 0D02. A late done arriving 2 clocks after rst deasserts is ignored.
6. INT toggled during CFG -> ignored. After config, INT low -> no reads, vld stays 0 for 200 clocks.
